state_sequencer: RTL and testbench

Clocked state register and sequencer that drives the `s0`–`s3` / `ns0`–`ns3` state lines and the `ws` write-strobe phase consumed by the control decoder. It walks each instruction through FETCH, optional DEREF, optional LOAD, EXEC and optional multi-cycle ALU shift states. It also implements front-panel run/single-step control, halting cleanly on instruction boundaries.

---
 rtl/state_sequencer.sv | 133 +++++++++++++
 tb/tb_state_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/state_sequencer.sv
// Two-phase instruction sequencer: FETCH/DEREF/LOAD/EXEC/ALU states,
// with front-panel run and single-step control.
module state_sequencer #(
  parameter int ALU_BITS = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       run,
  input  logic       step,
  input  logic [2:0] o,
  input  logic       deref,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       ns0,
  output logic       ns1,
  output logic       ns2,
  output logic       ns3,
  output logic       ws,
  output logic       halted
);

  localparam logic [3:0] FETCH     = 4'b0000;
  localparam logic [3:0] DEREF     = 4'b0001;
  localparam logic [3:0] LOAD      = 4'b0010;
  localparam logic [3:0] EXEC      = 4'b0011;
  localparam logic [3:0] ALU_SHIFT = 4'b0100;
  localparam logic [3:0] ALU_LAST  = 4'b1000;

  localparam int CW =
    (ALU_BITS > 1) ? $clog2(ALU_BITS) : 1;
  localparam logic [CW-1:0] LAST_CNT =
    (ALU_BITS > 1) ? CW'(ALU_BITS - 2) : '0;

  logic [3:0]    st_q;
  logic [3:0]    st_d;
  logic          ws_q;
  logic          halted_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    op_q;
  logic          dr_q;
  logic          pend_q;
  logic          step_q;

  logic [3:0] ir_d;
  logic       go;
  logic       step_edge;
  logic       fetch_a;

  // At FETCH the live IR bits are the ones being captured this edge.
  assign ir_d = (st_q == FETCH) ? {deref, o}
                                : {dr_q, op_q};

  assign go        = run | pend_q;
  assign step_edge = step & ~step_q;
  assign fetch_a   = (st_q == FETCH) & ~ws_q;

  always_comb begin
    st_d = FETCH;
    unique case (st_q)
      FETCH:
        if (ir_d[3])      st_d = DEREF;
        else if (ir_d[2]) st_d = EXEC;
        else              st_d = LOAD;
      DEREF:
        st_d = ir_d[2] ? EXEC : LOAD;
      LOAD:
        st_d = EXEC;
      EXEC:
        if (ir_d[2] && (ir_d[1] | ir_d[0]))
          st_d = (ALU_BITS == 1) ? ALU_LAST
                                 : ALU_SHIFT;
        else
          st_d = FETCH;
      ALU_SHIFT:
        st_d = (cnt_q == LAST_CNT) ? ALU_LAST
                                   : ALU_SHIFT;
      ALU_LAST:
        st_d = FETCH;
      default:
        st_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st_q     <= FETCH;
      ws_q     <= 1'b0;
      halted_q <= 1'b1;
      cnt_q    <= '0;
      op_q     <= 3'b000;
      dr_q     <= 1'b0;
      pend_q   <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      step_q <= step;
      if (fetch_a) begin
        if (go) begin
          ws_q     <= 1'b1;
          halted_q <= 1'b0;
          pend_q   <= 1'b0;
        end else begin
          halted_q <= 1'b1;
          if (step_edge)
            pend_q <= 1'b1;
        end
      end else begin
        if (!run && step_edge)
          pend_q <= 1'b1;
        if (ws_q) begin
          ws_q <= 1'b0;
          st_q <= st_d;
          {dr_q, op_q} <= ir_d;
          if (st_q == ALU_SHIFT)
            cnt_q <= cnt_q + 1'b1;
          else if (st_q == ALU_LAST)
            cnt_q <= '0;
          if (st_d == FETCH)
            halted_q <= ~go;
        end else begin
          ws_q <= 1'b1;
        end
      end
    end
  end

  assign {s3, s2, s1, s0}     = st_q;
  assign {ns3, ns2, ns1, ns0} = ~st_q;
  assign ws     = ws_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer: sequences, run/step
// control and asynchronous reset against hand-derived values.
module tb_state_sequencer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [2:0] o = 3'b000;
  logic       deref = 1'b0;
  logic       s0, s1, s2, s3;
  logic       ns0, ns1, ns2, ns3;
  logic       ws, halted;

  int n_chk  = 0;
  int n_pass = 0;

  state_sequencer #(.ALU_BITS(8)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .run    (run),
    .step   (step),
    .o      (o),
    .deref  (deref),
    .s0     (s0),
    .s1     (s1),
    .s2     (s2),
    .s3     (s3),
    .ns0    (ns0),
    .ns1    (ns1),
    .ns2    (ns2),
    .ns3    (ns3),
    .ws     (ws),
    .halted (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic chk_now(input string tag,
                         input logic [4:0] exp);
    logic [3:0] nexp;
    nexp = ~exp[4:1];
    chk(tag, {27'd0, s3, s2, s1, s0, ws},
        {27'd0, exp});
    chk({tag, "_ns"}, {28'd0, ns3, ns2, ns1, ns0},
        {28'd0, nexp});
  endtask

  task automatic obs(input string tag,
                     input logic [4:0] exp);
    @(negedge clk);
    chk_now(tag, exp);
  endtask

  task automatic alu_tail(input string tag);
    for (int i = 0; i < 7; i++) begin
      obs({tag, "_sha"}, 5'b01000);
      obs({tag, "_shb"}, 5'b01001);
    end
    obs({tag, "_lsa"}, 5'b10000);
    obs({tag, "_lsb"}, 5'b10001);
    obs({tag, "_fa"},  5'b00000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    // reset values
    @(negedge clk);
    chk_now("rst", 5'b00000);
    chk("rst_halt", {31'd0, halted}, 32'd1);

    // free run, o=001 no deref: FETCH LOAD EXEC
    nrst = 1'b1; run = 1'b1; o = 3'b001; deref = 1'b0;
    chk("t1_halt0", {31'd0, halted}, 32'd1);
    obs("t1_fb", 5'b00001);
    chk("t1_run", {31'd0, halted}, 32'd0);
    obs("t1_la", 5'b00100);
    obs("t1_lb", 5'b00101);
    obs("t1_ea", 5'b00110);
    obs("t1_eb", 5'b00111);
    obs("t1_fa", 5'b00000);
    chk("t1_halt", {31'd0, halted}, 32'd0);

    // o=100 deref=1: FETCH DEREF EXEC
    o = 3'b100; deref = 1'b1;
    obs("t2_fb", 5'b00001);
    obs("t2_da", 5'b00010);
    obs("t2_db", 5'b00011);
    obs("t2_ea", 5'b00110);
    obs("t2_eb", 5'b00111);
    obs("t2_fa", 5'b00000);

    // o=000 deref=1: FETCH DEREF LOAD EXEC
    o = 3'b000; deref = 1'b1;
    obs("t2b_fb", 5'b00001);
    obs("t2b_da", 5'b00010);
    obs("t2b_db", 5'b00011);
    obs("t2b_la", 5'b00100);
    obs("t2b_lb", 5'b00101);
    obs("t2b_ea", 5'b00110);
    obs("t2b_eb", 5'b00111);
    obs("t2b_fa", 5'b00000);

    // ALU o=110: 7 shift states then last
    o = 3'b110; deref = 1'b0;
    obs("t3_fb", 5'b00001);
    obs("t3_ea", 5'b00110);
    obs("t3_eb", 5'b00111);
    alu_tail("t3");

    // halted after reset with run=0
    nrst = 1'b0; run = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({s3, s2, s1, s0, ws} !== 5'b00000 ||
          halted !== 1'b1)
        bad++;
    end
    chk("t4_idle50", bad, 0);

    // single step runs one instruction
    o = 3'b001; deref = 1'b0; step = 1'b1;
    obs("t4_pend", 5'b00000);
    chk("t4_pend_h", {31'd0, halted}, 32'd1);
    step = 1'b0;
    obs("t4_fb", 5'b00001);
    chk("t4_go_h", {31'd0, halted}, 32'd0);
    obs("t4_la", 5'b00100);
    obs("t4_lb", 5'b00101);
    obs("t4_ea", 5'b00110);
    obs("t4_eb", 5'b00111);
    obs("t4_fa", 5'b00000);
    chk("t4_end_h", {31'd0, halted}, 32'd1);
    obs("t4_hold", 5'b00000);
    chk("t4_hold_h", {31'd0, halted}, 32'd1);

    // run drop during LOAD; a step edge while running is ignored
    run = 1'b1; o = 3'b010;
    obs("t5_fb", 5'b00001);
    chk("t5_go_h", {31'd0, halted}, 32'd0);
    step = 1'b1;
    obs("t5_la", 5'b00100);
    step = 1'b0; run = 1'b0;
    obs("t5_lb", 5'b00101);
    obs("t5_ea", 5'b00110);
    obs("t5_eb", 5'b00111);
    obs("t5_fa", 5'b00000);
    chk("t5_h", {31'd0, halted}, 32'd1);
    obs("t5_hold1", 5'b00000);
    obs("t5_hold2", 5'b00000);
    chk("t5_hold_h", {31'd0, halted}, 32'd1);

    // async reset at shift count 3
    run = 1'b1; o = 3'b110;
    obs("t6_fb", 5'b00001);
    obs("t6_ea", 5'b00110);
    obs("t6_eb", 5'b00111);
    for (int i = 0; i < 3; i++) begin
      obs("t6_sha", 5'b01000);
      obs("t6_shb", 5'b01001);
    end
    obs("t6_c3", 5'b01000);
    #2 nrst = 1'b0;
    #1;
    chk_now("t6_rst", 5'b00000);
    chk("t6_rst_h", {31'd0, halted}, 32'd1);
    @(negedge clk);
    nrst = 1'b1;
    obs("t6_fb2", 5'b00001);
    obs("t6_ea2", 5'b00110);
    obs("t6_eb2", 5'b00111);
    alu_tail("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
